// File: rtl/stream_packetizer_if.sv
// Packet record type and the word-in / byte-out bus bundle for stream_packetizer.
// The slave modport is the packetizer side; the master modport is its environment.
package stream_packetizer_pkg;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;
endpackage

interface stream_packetizer_if #(
  parameter int DEPTH = 16
) ();
  import stream_packetizer_pkg::*;

  logic [15:0]            ipWord;
  logic                   ipWordValid;
  logic                   opWordReady;
  logic                   ipTxReady;
  UART_PACKET             opTxStream;
  logic [$clog2(DEPTH):0] opFIFO_Size;

  modport slave  (input  ipWord, ipWordValid, ipTxReady,
                  output opWordReady, opTxStream, opFIFO_Size);
  modport master (output ipWord, ipWordValid, ipTxReady,
                  input  opWordReady, opTxStream, opFIFO_Size);
endinterface

// File: rtl/stream_packetizer.sv
// Buffers 16-bit words and frames them into UART_PACKET byte streams, low byte first.
// Optional trailing XOR checksum byte when STREAM_PACKETIZER_CHECKSUM_EN is defined.
//
// state      | meaning
// S_IDLE     | waiting for a full payload or a timed-out partial one
// S_LOAD     | latch word count N and Length for the next packet
// S_SEND_LO  | presenting low byte of FIFO head
// S_SEND_HI  | presenting high byte; pops the word on acceptance
// S_SEND_SUM | presenting checksum byte (checksum build only)
module stream_packetizer
  import stream_packetizer_pkg::*;
#(
  parameter int         DEPTH         = 16,
  parameter int         WORDS_PER_PKT = 4,
  parameter int         TIMEOUT       = 50000,
  parameter logic [7:0] DEST_ADDR     = 8'h01,
  parameter logic [7:0] SRC_ADDR      = 8'h10
) (
  input  logic          ipClk,
  input  logic          ipReset,
  stream_packetizer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WPP_C   = CW'(WORDS_PER_PKT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND_LO, S_SEND_HI, S_SEND_SUM} state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d, n_words;
  logic [TW-1:0] timer_q, timer_d;
  logic [6:0]    remain_q, remain_d;
  logic [7:0]    len_q, len_d;
  logic          first_q, first_d;
  logic          push, pop, start_now, start_next;
  logic [15:0]   head;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  assign head            = mem_q[rd_ptr_q];
  assign bus.opWordReady = (count_q != DEPTH_C);
  assign bus.opFIFO_Size = count_q;
  assign push            = bus.ipWordValid && bus.opWordReady;
  assign pop             = (state_q == S_SEND_HI) && bus.ipTxReady;
  assign count_d         = count_q + CW'(push) - CW'(pop);
  assign n_words         = (count_q >= WPP_C) ? WPP_C : count_q;

  always_comb begin
    timer_d = timer_q;
    if (push || count_q == '0)
      timer_d = '0;
    else if (state_q == S_IDLE && timer_q != TMO_C)
      timer_d = timer_q + 1'b1;
  end

  assign start_now  = (count_q >= WPP_C) || (count_q != '0 && timer_q == TMO_C);
  // Evaluated on the last byte so a ready payload skips Idle and the gap is just Load.
  assign start_next = (count_d >= WPP_C) || (count_d != '0 && timer_d == TMO_C);

  always_comb begin
    state_d        = state_q;
    remain_d       = remain_q;
    len_d          = len_q;
    first_d        = first_q;
    bus.opTxStream = '0;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    csum_d         = csum_q;
`endif
    if (state_q == S_SEND_LO || state_q == S_SEND_HI || state_q == S_SEND_SUM) begin
      bus.opTxStream.Valid       = 1'b1;
      bus.opTxStream.Source      = SRC_ADDR;
      bus.opTxStream.Destination = DEST_ADDR;
      bus.opTxStream.Length      = len_q;
    end
    case (state_q)
      S_IDLE: if (start_now) state_d = S_LOAD;
      S_LOAD: begin
        remain_d = 7'(n_words);
        first_d  = 1'b1;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
        len_d    = 8'({n_words, 1'b0}) + 8'd1;
        csum_d   = '0;
`else
        len_d    = 8'({n_words, 1'b0});
`endif
        state_d  = S_SEND_LO;
      end
      S_SEND_LO: begin
        bus.opTxStream.Data = head[7:0];
        bus.opTxStream.SoP  = first_q;
        if (bus.ipTxReady) begin
          first_d = 1'b0;
          state_d = S_SEND_HI;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
          csum_d  = csum_q ^ head[7:0];
`endif
        end
      end
      S_SEND_HI: begin
        bus.opTxStream.Data = head[15:8];
`ifndef STREAM_PACKETIZER_CHECKSUM_EN
        bus.opTxStream.EoP  = (remain_q == 7'd1);
`endif
        if (bus.ipTxReady) begin
          remain_d = remain_q - 7'd1;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
          csum_d   = csum_q ^ head[15:8];
          state_d  = (remain_q == 7'd1) ? S_SEND_SUM : S_SEND_LO;
`else
          if (remain_q == 7'd1) state_d = start_next ? S_LOAD : S_IDLE;
          else                  state_d = S_SEND_LO;
`endif
        end
      end
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
      S_SEND_SUM: begin
        bus.opTxStream.Data = csum_q;
        bus.opTxStream.EoP  = 1'b1;
        if (bus.ipTxReady) state_d = start_next ? S_LOAD : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      remain_q <= '0;
      len_q    <= '0;
      first_q  <= 1'b0;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      remain_q <= remain_d;
      len_q    <= len_d;
      first_q  <= first_d;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge ipClk) begin
    if (push) mem_q[wr_ptr_q] <= bus.ipWord;
  end
endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer: stimulus queues expected bytes, a monitor checks them.
// Honours STREAM_PACKETIZER_CHECKSUM_EN the same way as the design.
module tb_stream_packetizer;
  import stream_packetizer_pkg::*;

  localparam int TMO = 64;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] len;
  } exp_t;

  logic ipClk = 1'b0;
  logic ipReset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_bytes  = 0;
  logic       hold_q = 1'b0;
  UART_PACKET prev_q;

  stream_packetizer_if #(.DEPTH(16)) bus ();

  stream_packetizer #(
    .DEPTH(16), .WORDS_PER_PKT(4), .TIMEOUT(TMO), .DEST_ADDR(8'h01), .SRC_ADDR(8'h10)
  ) dut (
    .ipClk  (ipClk),
    .ipReset(ipReset),
    .bus    (bus)
  );

  always #5 ipClk = ~ipClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected byte stream for one packet built from the given words.
  task automatic exp_packet(input logic [15:0] ws[$]);
    logic [7:0] len, x;
    exp_t e;
    len = 8'(2 * ws.size() + CS);
    x   = '0;
    foreach (ws[i]) begin
      e = '{data: ws[i][7:0],  sop: (i == 0), eop: 1'b0, len: len};
      exp_q.push_back(e);
      e = '{data: ws[i][15:8], sop: 1'b0, eop: (CS == 0 && i == ws.size() - 1), len: len};
      exp_q.push_back(e);
      x = x ^ ws[i][7:0] ^ ws[i][15:8];
    end
    if (CS != 0) begin
      e = '{data: x, sop: 1'b0, eop: 1'b1, len: len};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.ipWord      = w;
    bus.ipWordValid = 1'b1;
    @(posedge ipClk); #1;
    bus.ipWordValid = 1'b0;
  endtask

  task automatic wait_drain(input int maxc, output int c);
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(posedge ipClk); #1;
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge ipClk) begin
    exp_t e;
    if (ipReset && bus.opTxStream.Valid) begin
      if (hold_q) chk("hold_stable", 64'(bus.opTxStream), 64'(prev_q));
      if (bus.ipTxReady) begin
        n_bytes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.opTxStream.Data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte",
              64'({bus.opTxStream.Data, bus.opTxStream.SoP, bus.opTxStream.EoP,
                   bus.opTxStream.Length, bus.opTxStream.Source, bus.opTxStream.Destination}),
              64'({e.data, e.sop, e.eop, e.len, 8'h10, 8'h01}));
        end
      end
      hold_q <= !bus.ipTxReady;
      prev_q <= bus.opTxStream;
    end else begin
      hold_q <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] q[$];
    int c, base, k;
    logic early;

    ipReset         = 1'b0;
    bus.ipWord      = '0;
    bus.ipWordValid = 1'b0;
    bus.ipTxReady   = 1'b0;
    #1;
    chk("rst_stream", 64'(bus.opTxStream), 64'd0);
    chk("rst_ready",  64'(bus.opWordReady), 64'd1);
    chk("rst_size",   64'(bus.opFIFO_Size), 64'd0);
    repeat (3) @(posedge ipClk);
    #1 ipReset = 1'b1;

    // Full packet, transmitter always ready
    bus.ipTxReady = 1'b1;
    q = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    exp_packet(q);
    foreach (q[i]) push_word(q[i]);
    wait_drain(100, c);
    repeat (2) @(posedge ipClk); #1;
    chk("t1_size", 64'(bus.opFIFO_Size), 64'd0);

    // Single word flushed by timeout
    q = {16'hA55A};
    exp_packet(q);
    push_word(16'hA55A);
    early = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge ipClk);
      if (bus.opTxStream.Valid) early = 1'b1;
    end
    chk("no_early_valid", 64'(early), 64'd0);
    wait_drain(50, c);

    // Backpressure pattern 1,0,0,1
    bus.ipTxReady = 1'b0;
    q = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    exp_packet(q);
    foreach (q[i]) push_word(q[i]);
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      bus.ipTxReady = (k % 4 == 0) || (k % 4 == 3);
      @(posedge ipClk); #1;
      k++;
    end
    chk("t3_left", 64'(exp_q.size()), 64'd0);
    bus.ipTxReady = 1'b1;
    repeat (3) @(posedge ipClk); #1;

    // Fill past full with transmitter stalled
    bus.ipTxReady = 1'b0;
    for (int p = 0; p < 4; p++) begin
      q = {};
      for (int j = 0; j < 4; j++) q.push_back(16'hC000 + 16'((p * 4 + j) * 16'h0101));
      exp_packet(q);
    end
    for (int i = 0; i < 20; i++) begin
      bus.ipWord      = 16'hC000 + 16'(i * 16'h0101);
      bus.ipWordValid = 1'b1;
      @(posedge ipClk); #1;
    end
    bus.ipWordValid = 1'b0;
    chk("full_ready", 64'(bus.opWordReady), 64'd0);
    chk("full_size",  64'(bus.opFIFO_Size), 64'd16);
    bus.ipTxReady = 1'b1;
    wait_drain(200, c);
    chk("full_drain_cycles", 64'(c), 64'(4 * (8 + CS) + 3));
    repeat (2) @(posedge ipClk); #1;
    chk("full_size_end", 64'(bus.opFIFO_Size), 64'd0);

    // Reset after the third byte of a packet
    q = {16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011};
    exp_packet(q);
    base = n_bytes;
    foreach (q[i]) push_word(q[i]);
    k = 0;
    while (n_bytes < base + 3 && k < 50) begin
      @(posedge ipClk); #1;
      k++;
    end
    chk("rst_mid_reached", 64'(n_bytes - base), 64'd3);
    ipReset = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_valid", 64'(bus.opTxStream.Valid), 64'd0);
    chk("rst_mid_size",  64'(bus.opFIFO_Size), 64'd0);
    @(posedge ipClk); #1 ipReset = 1'b1;
    q = {16'h2222, 16'h3333, 16'h4444, 16'h5555};
    exp_packet(q);
    foreach (q[i]) push_word(q[i]);
    wait_drain(100, c);

`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    // Checksum byte on a two-word packet: 02,01,04,03,04
    q = {16'h0102, 16'h0304};
    exp_packet(q);
    chk("cs_value", 64'(exp_q[4].data), 64'h04);
    foreach (q[i]) push_word(q[i]);
    wait_drain(TMO + 50, c);
`endif

    repeat (3) @(posedge ipClk); #1;
    chk("end_size", 64'(bus.opFIFO_Size), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_packetizer.md
Name: stream_packetizer

Overview:
- Transmit-side counterpart of the receive streamer: collects 16-bit words from the modulator datapath and frames them into UART_PACKET byte streams for the UART transmitter.
- Buffers words in an internal FIFO and sends a packet when a full payload is ready or a timeout expires. Bytes go out low byte then high byte, the same order the receive streamer reassembles.

Parameters:
- DEPTH, 16, internal word FIFO depth (power of 2, ≥ WORDS_PER_PKT)
- WORDS_PER_PKT, 4, max words per packet (1..127)
- TIMEOUT, 50000, idle cycles before a partial packet is flushed
- DEST_ADDR, 8'h01, Destination field value
- SRC_ADDR, 8'h10, Source field value

Ports:
- ipClk  in  1  system clock
- ipReset  in  1  asynchronous, active-low reset
- ipWord  in  16  payload word
- ipWordValid  in  1  word strobe; accepted when opWordReady=1
- opWordReady  out  1  internal FIFO not full
- ipTxReady  in  1  UART transmitter can take a byte this cycle
- opTxStream  out  UART_PACKET  fields Valid, SoP, EoP, Source[7:0], Destination[7:0], Length[7:0], Data[7:0]
- opFIFO_Size  out  $clog2(DEPTH)+1  words currently buffered

Behaviour:
- Reset (async assert, sync release): FIFO empty, opWordReady=1, opTxStream all fields 0, opFIFO_Size=0, timeout counter 0, state Idle.
- Write: push when ipWordValid && opWordReady. A push and a pop in the same cycle leave the count unchanged. opFIFO_Size is registered and updates the cycle after the push or pop.
- Timeout counter: clears on any push or while the FIFO is empty; otherwise increments in Idle and saturates at TIMEOUT.
- Idle → Load when count ≥ WORDS_PER_PKT, or when count ≥ 1 and the timer has reached TIMEOUT.
- Load (1 cycle): latch N = min(count, WORDS_PER_PKT) and set Length = 2N. Go to SendLo.
- SendLo:
  - Present the low byte of the FIFO head with Valid=1.
  - SoP=1 only on the first byte of the packet.
  - On acceptance (Valid && ipTxReady), go to SendHi.
- SendHi:
  - Present the high byte.
  - On acceptance, pop the word and decrement the remaining count.
  - Last word: EoP=1 on this byte, then go to Idle.
  - Otherwise go to SendLo.
- Handshake:
  - Data, SoP, EoP, Source, Destination and Length stay stable while Valid=1 && ipTxReady=0.
  - Valid never drops before acceptance.
  - Source, Destination and Length are constant for the whole packet.
- Throughput: one byte per cycle when ipTxReady is held high. Valid deasserts for exactly one cycle between packets (Idle/Load).
- Pushes during a packet are allowed. Words arriving mid-packet are not added to it; the packet carries exactly N words.
- FIFO full: opWordReady=0 and ipWordValid is ignored (word dropped upstream's responsibility).
- Reset mid-packet: packet is abandoned with no EoP; all state returns to reset values.

Optional Feature:
- Macro STREAM_PACKETIZER_CHECKSUM_EN.
- Defined:
  - Adds a SendSum state after the last SendHi.
  - Sends one extra byte, the XOR of all 2N payload bytes.
  - EoP moves to this checksum byte; Length = 2N+1.
- Undefined: no checksum byte and Length = 2N; EoP sits on the last high byte.

Test Plan:
- Push 4 words 0x1234,0x5678,0x9ABC,0xDEF0 with ipTxReady=1 → 8 bytes 34,12,78,56,BC,9A,F0,DE; SoP on 0x34, EoP on 0xDE; Length=8, Dest=01, Src=10; opFIFO_Size returns to 0.
- Push 1 word 0xA55A, then idle → no Valid before TIMEOUT idle cycles; afterwards bytes 5A,A5 with SoP on 0x5A, EoP on 0xA5, Length=2.
- Same 4 words with ipTxReady toggled 1,0,0,1,… → each byte held stable while ipTxReady=0; the byte sequence matches the first test.
- Push 20 words with ipTxReady=0 → opWordReady falls at 16 buffered; the 17th–20th words are not accepted; opFIFO_Size=16. Release ipTxReady → four packets of Length 8 each.
- Assert ipReset low mid-packet after byte 3 → opTxStream.Valid=0 immediately; opFIFO_Size=0; the next packet starts with SoP.
- CHECKSUM_EN, words 0x0102,0x0304 → bytes 02,01,04,03,04; EoP on the final 0x04; Length=5.
